xmm_writeback_queue: RTL and testbench
======================================

Name: xmm_writeback_queue

Overview:
- Write-side companion to the 32-entry q15.48 Xmm register file.
- Buffers results from multi-cycle fixed-point units (mul/div/sqrt) in a small in-order FIFO and drains at most one write per cycle onto the register file's write port (should_write/write_addr/write_data).
- Keeps a per-register pending scoreboard so issue logic can stall on read-after-write hazards against not-yet-written results.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- DATA_W, 64: result width (signed q15.48).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low (asserted at 0).
- push_valid  in  1  producer offers a result.
- push_ready  out  1  queue can accept a result this cycle.
- push_addr  in  5  destination Xmm register.
- push_data  in  DATA_W  result value.
- drain_hold  in  1  when 1, no write is presented and no pop occurs.
- should_write  out  1  to register file; a valid head entry is presented.
- write_addr  out  5  to register file; head destination.
- write_data  out  DATA_W  to register file; head value.
- query_addr1  in  5  hazard query, operand 1.
- query_addr2  in  5  hazard query, operand 2.
- busy1  out  1  query_addr1 has at least one queued write.
- busy2  out  1  query_addr2 has at least one queued write.
- pending_mask  out  32  bit i set iff register i has a queued write.
- occupancy  out  $clog2(DEPTH+1)  number of entries held.

Behaviour:
- Reset (reset==0, async):
  - FIFO emptied; all pending counters 0.
  - should_write=0, write_addr=0, write_data=0, busy1=busy2=0, pending_mask=0, occupancy=0, push_ready=1.
  - A reset asserted mid-drain discards all queued entries; no further writes reach the register file.
- Accept:
  - A push fires at posedge when push_valid && push_ready.
  - push_ready = (occupancy < DEPTH). No same-cycle pass-through when full, even if the head pops that edge.
- Register 0:
  - A push with push_addr==0 is accepted (handshake completes) but discarded: no entry is enqueued and no counter changes.
- Present:
  - should_write = !empty && !drain_hold.
  - write_addr and write_data show the head combinationally from FIFO storage.
  - Values are stable from posedge to posedge, so the register file's negedge write sees settled data.
- Pop:
  - The head pops at posedge when should_write==1.
  - Latency: a result pushed into an empty queue at edge N is presented during cycle N..N+1, written at the intervening negedge, and popped at edge N+1.
- Ordering: strict FIFO. Multiple entries for the same register retire oldest-first; the last write wins.
- Scoreboard:
  - One counter per register, width $clog2(DEPTH+1).
  - Increment on an enqueue to that address; decrement on a pop from that address.
  - If both happen in the same cycle for the same address, the counter is unchanged.
  - pending_mask[i] = (cnt[i]!=0); busy1 = pending_mask[query_addr1]; busy2 likewise.
  - Register 0 is never busy.
- Simultaneous push and pop: occupancy is unchanged; pointers wrap modulo DEPTH.
- drain_hold:
  - Freezes popping; pushes continue until full.
  - Deasserting drain_hold resumes draining the same cycle (combinational).
- No arithmetic is applied to data; values pass through bit-exact.

Optional Feature:
- Macro: XMM_WB_FORWARD_EN.
- Defined:
  - Adds outputs fwd_hit1/fwd_hit2 (1 bit) and fwd_data1/fwd_data2 (DATA_W).
  - fwd_hitK = busyK.
  - fwd_dataK = data of the youngest queued entry whose addr equals query_addrK; 0 when there is no hit.
  - Lets issue bypass instead of stalling.
- Undefined: these ports and the youngest-match search logic do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package xmm_pkg:
  - XMM_ADDR_W=5, XMM_NREGS=32, XMM_DATA_W=64, XMM_FRAC_BITS=48.
  - Typedef xmm_wb_entry_t {addr, data}.
- One natural sub-module, xmm_wb_fifo: storage plus read/write pointers, count, full/empty.
- The top level holds the scoreboard counters, the register-0 filter and forwarding.

Test Plan:
- Reset then push {addr=3, data=0x0001_0000_0000_0000} into the empty queue at edge N -> should_write=1, write_addr=3 during cycle N..N+1; busy for reg 3 high; popped at N+1; pending_mask=0 after.
- Push addr=0, data=0xDEAD -> push_ready handshake completes; occupancy stays 0; should_write never asserts.
- drain_hold=1, push 5 results -> first 4 accepted, push_ready=0 on the 5th; occupancy=4; release hold -> 4 writes in FIFO order on consecutive cycles.
- Two pushes to reg 7 (data 1 then 2) with a third to reg 9 -> cnt[7]=2, busy1=1 for query_addr1=7 until the second reg-7 pop; final write order 7:1, 7:2, 9.
- Push to reg 5 and pop a reg-5 head in the same cycle -> cnt[5] unchanged, occupancy unchanged.
- Assert reset with 3 entries queued -> should_write drops immediately (asynchronously); after release occupancy=0 and pending_mask=0. With XMM_WB_FORWARD_EN, before reset fwd_data1 for reg 7 = youngest value 2.

Source files
------------

// File: rtl/xmm_pkg.sv
// Shared definitions for the Xmm q15.48 register file and its write-back path.
package xmm_pkg;

  localparam int XMM_ADDR_W    = 5;
  localparam int XMM_NREGS     = 32;
  localparam int XMM_DATA_W    = 64;
  localparam int XMM_FRAC_BITS = 48;

  typedef struct packed {
    logic [XMM_ADDR_W-1:0] addr;
    logic [XMM_DATA_W-1:0] data;
  } xmm_wb_entry_t;

endpackage

// File: rtl/xmm_wb_fifo.sv
// In-order result FIFO with combinational head read. With XMM_WB_FORWARD_EN the
// storage and read pointer are exported so the top can search for forwarding.
module xmm_wb_fifo
  import xmm_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = XMM_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [XMM_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [XMM_ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0]     head_data,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
`ifdef XMM_WB_FORWARD_EN
  ,
  output logic [PTR_W-1:0]      rd_ptr,
  output logic [XMM_ADDR_W-1:0] mem_addr_q [DEPTH],
  output logic [DATA_W-1:0]     mem_data_q [DEPTH]
`endif
);

  logic [XMM_ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0]     mem_data [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  do_wr;
  logic                  do_rd;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage is not reset; the head is masked to zero whenever the queue is empty.
  assign head_addr = empty ? '0 : mem_addr[rd_ptr_reg];
  assign head_data = empty ? '0 : mem_data[rd_ptr_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_addr[wr_ptr_reg] <= wr_addr;
      mem_data[wr_ptr_reg] <= wr_data;
    end
  end

`ifdef XMM_WB_FORWARD_EN
  assign rd_ptr     = rd_ptr_reg;
  assign mem_addr_q = mem_addr;
  assign mem_data_q = mem_data;
`endif

endmodule

// File: rtl/xmm_writeback_queue.sv
// Write-back queue for the Xmm register file: FIFO drain, register-0 filter and
// per-register pending scoreboard. Optional bypass data under XMM_WB_FORWARD_EN.
module xmm_writeback_queue
  import xmm_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = XMM_DATA_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [XMM_ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  drain_hold,
  output logic                  should_write,
  output logic [XMM_ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0]     write_data,
  input  logic [XMM_ADDR_W-1:0] query_addr1,
  input  logic [XMM_ADDR_W-1:0] query_addr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic [XMM_NREGS-1:0]  pending_mask,
  output logic [CNT_W-1:0]      occupancy
`ifdef XMM_WB_FORWARD_EN
  ,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [DATA_W-1:0]     fwd_data1,
  output logic [DATA_W-1:0]     fwd_data2
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic push_fire;
  logic enq;
  logic full;
  logic empty;

`ifdef XMM_WB_FORWARD_EN
  logic [PTR_W-1:0]      rd_ptr;
  logic [XMM_ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0]     mem_data [DEPTH];
`endif

  assign push_ready   = !full;
  assign push_fire    = push_valid && push_ready;
  // Writes to register 0 complete the handshake but are dropped here.
  assign enq          = push_fire && (push_addr != '0);
  assign should_write = !empty && !drain_hold;

  xmm_wb_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (enq),
    .wr_addr  (push_addr),
    .wr_data  (push_data),
    .rd_en    (should_write),
    .head_addr(write_addr),
    .head_data(write_data),
    .count    (occupancy),
    .full     (full),
    .empty    (empty)
`ifdef XMM_WB_FORWARD_EN
    ,
    .rd_ptr    (rd_ptr),
    .mem_addr_q(mem_addr),
    .mem_data_q(mem_data)
`endif
  );

  genvar gi;
  generate
    for (gi = 0; gi < XMM_NREGS; gi++) begin : g_sb
      logic [CNT_W-1:0] cnt_reg;
      logic             inc;
      logic             dec;

      assign inc = enq && (push_addr == XMM_ADDR_W'(gi));
      assign dec = should_write && (write_addr == XMM_ADDR_W'(gi));
      assign pending_mask[gi] = (cnt_reg != '0);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (inc != dec) begin
          cnt_reg <= inc ? cnt_reg + 1'b1 : cnt_reg - 1'b1;
        end
      end
    end
  endgenerate

  assign busy1 = pending_mask[query_addr1];
  assign busy2 = pending_mask[query_addr2];

`ifdef XMM_WB_FORWARD_EN
  // Scan oldest to youngest so the last match (youngest) wins.
  function automatic logic [DATA_W-1:0] youngest_match(input logic [XMM_ADDR_W-1:0] q);
    logic [DATA_W-1:0] d;
    logic [PTR_W-1:0]  idx;
    d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < occupancy) && (mem_addr[idx] == q)) d = mem_data[idx];
    end
    return d;
  endfunction

  assign fwd_hit1  = busy1;
  assign fwd_hit2  = busy2;
  assign fwd_data1 = youngest_match(query_addr1);
  assign fwd_data2 = youngest_match(query_addr2);
`endif

endmodule

// File: tb/tb_xmm_writeback_queue.sv
// Randomized and directed bench for xmm_writeback_queue against a queue-based model.
module tb_xmm_writeback_queue;
  import xmm_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              push_valid = 1'b0;
  logic              push_ready;
  logic [4:0]        push_addr = '0;
  logic [DATA_W-1:0] push_data = '0;
  logic              drain_hold = 1'b0;
  logic              should_write;
  logic [4:0]        write_addr;
  logic [DATA_W-1:0] write_data;
  logic [4:0]        query_addr1 = '0;
  logic [4:0]        query_addr2 = '0;
  logic              busy1;
  logic              busy2;
  logic [31:0]       pending_mask;
  logic [CNT_W-1:0]  occupancy;
`ifdef XMM_WB_FORWARD_EN
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;
`endif

  always #5 clk = ~clk;

  xmm_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .push_addr   (push_addr),
    .push_data   (push_data),
    .drain_hold  (drain_hold),
    .should_write(should_write),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .query_addr1 (query_addr1),
    .query_addr2 (query_addr2),
    .busy1       (busy1),
    .busy2       (busy2),
    .pending_mask(pending_mask),
    .occupancy   (occupancy)
`ifdef XMM_WB_FORWARD_EN
    ,
    .fwd_hit1    (fwd_hit1),
    .fwd_hit2    (fwd_hit2),
    .fwd_data1   (fwd_data1),
    .fwd_data2   (fwd_data2)
`endif
  );

  xmm_wb_entry_t model_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (model_q[i]) m[model_q[i].addr] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_fwd(input logic [4:0] a);
    logic [63:0] d;
    d = '0;
    foreach (model_q[i]) if (model_q[i].addr == a) d = model_q[i].data;
    return d;
  endfunction

  // One clock cycle: drive, check mid-cycle against the model, then advance the model at the edge.
  task automatic step(input logic v, input logic [4:0] a, input logic [63:0] d,
                      input logic h, input logic [4:0] q1, input logic [4:0] q2);
    int            n;
    logic          exp_sw;
    logic [31:0]   m;
    xmm_wb_entry_t e;
    push_valid  = v;
    push_addr   = a;
    push_data   = d;
    drain_hold  = h;
    query_addr1 = q1;
    query_addr2 = q2;
    @(negedge clk);
    n      = model_q.size();
    m      = model_mask();
    exp_sw = (n > 0) && !h;
    check("push_ready",   push_ready,   (n < DEPTH));
    check("should_write", should_write, exp_sw);
    check("write_addr",   write_addr,   (n > 0) ? model_q[0].addr : 5'd0);
    check("write_data",   write_data,   (n > 0) ? model_q[0].data : 64'd0);
    check("occupancy",    occupancy,    n);
    check("pending_mask", pending_mask, m);
    check("busy1",        busy1,        m[q1]);
    check("busy2",        busy2,        m[q2]);
`ifdef XMM_WB_FORWARD_EN
    check("fwd_hit1",  fwd_hit1,  m[q1]);
    check("fwd_hit2",  fwd_hit2,  m[q2]);
    check("fwd_data1", fwd_data1, model_fwd(q1));
    check("fwd_data2", fwd_data2, model_fwd(q2));
`endif
    @(posedge clk);
    if (exp_sw) begin
      $display("write r%0d <= %016h", model_q[0].addr, model_q[0].data);
      void'(model_q.pop_front());
    end
    if (v && (n < DEPTH) && (a != 5'd0)) begin
      e.addr = a;
      e.data = d;
      model_q.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input int cycles, input logic [4:0] q1);
    for (int i = 0; i < cycles; i++) step(1'b0, 5'd0, 64'd0, 1'b0, q1, 5'd0);
  endtask

  initial begin
    #1;
    check("rst_should_write", should_write, 0);
    check("rst_write_addr",   write_addr,   0);
    check("rst_write_data",   write_data,   0);
    check("rst_occupancy",    occupancy,    0);
    check("rst_pending_mask", pending_mask, 0);
    check("rst_push_ready",   push_ready,   1);
    check("rst_busy",         {busy1, busy2}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Latency: push into empty queue, presented next cycle, popped at the following edge.
    step(1'b1, 5'd3, 64'h0001_0000_0000_0000, 1'b0, 5'd3, 5'd0);
    idle(2, 5'd3);

    // Register 0 is accepted but discarded.
    step(1'b1, 5'd0, 64'hDEAD, 1'b0, 5'd0, 5'd0);
    idle(2, 5'd0);

    // Fill under hold, fifth push refused, then drain in order.
    for (int i = 1; i <= 5; i++) step(1'b1, 5'(i), 64'(i * 16'h1111), 1'b1, 5'(i), 5'd5);
    idle(5, 5'd1);

    // Same-register stacking and in-order retirement.
    step(1'b1, 5'd7, 64'd1, 1'b1, 5'd7, 5'd9);
    step(1'b1, 5'd7, 64'd2, 1'b1, 5'd7, 5'd9);
    step(1'b1, 5'd9, 64'd3, 1'b1, 5'd7, 5'd9);
    idle(4, 5'd7);

    // Push to reg 5 while a reg-5 head pops.
    step(1'b1, 5'd5, 64'hA5, 1'b0, 5'd5, 5'd0);
    step(1'b1, 5'd5, 64'hB5, 1'b0, 5'd5, 5'd0);
    idle(2, 5'd5);

    // Asynchronous reset with three entries queued.
    step(1'b1, 5'd7, 64'd1, 1'b1, 5'd7, 5'd9);
    step(1'b1, 5'd7, 64'd2, 1'b1, 5'd7, 5'd9);
    step(1'b1, 5'd9, 64'd3, 1'b1, 5'd7, 5'd9);
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 5'd9);
    push_valid = 1'b0;
    drain_hold = 1'b0;
    #1;
    check("pre_reset_should_write", should_write, 1);
    reset = 1'b0;
    #1;
    check("async_should_write", should_write, 0);
    check("async_occupancy",    occupancy,    0);
    check("async_pending_mask", pending_mask, 0);
    check("async_push_ready",   push_ready,   1);
    model_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(2, 5'd7);

    // Randomized traffic with narrow addresses for frequent collisions.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      step($urandom_range(0, 99) < 60, a, {$urandom, $urandom}, $urandom_range(0, 3) == 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(DEPTH + 2, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
